// File: rtl/path_planner_bfs.sv
// path_planner_bfs: BFS shortest-hop planner over a runtime-writable undirected adjacency matrix
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start, s_node, e_node      plan request (rising edge) with start/end node ids
//   edge_we, edge_a, edge_b,
//   edge_val                   adjacency write (ignored while busy or if an endpoint is out of range)
//   done, busy                 idle/result-valid and planning indicators
//   no_path, path_ovf          unreachable/out-of-range end, or path longer than MAX_PATH nodes
//   path_len, final_path       node count and packed node list (slot k at [k*NODE_W +: NODE_W])
module path_planner_bfs #(
    parameter int N_NODES = 32,
    parameter int NODE_W = 5,
    parameter int MAX_PATH = 10,
    parameter logic [NODE_W-1:0] PAD = NODE_W'(27)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NODE_W-1:0]            s_node,
    input  logic [NODE_W-1:0]            e_node,
    input  logic                         edge_we,
    input  logic [NODE_W-1:0]            edge_a,
    input  logic [NODE_W-1:0]            edge_b,
    input  logic                         edge_val,
    output logic                         done,
    output logic                         busy,
    output logic                         no_path,
    output logic                         path_ovf,
    output logic [$clog2(MAX_PATH+1)-1:0] path_len,
    output logic [MAX_PATH*NODE_W-1:0]   final_path
);
    localparam int IDX_W = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam int LEN_W = $clog2(MAX_PATH + 1);
    localparam int CNT_W = LEN_W + 1;
    localparam int TB_W = (MAX_PATH > 1) ? $clog2(MAX_PATH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NODES - 1);
    localparam logic [NODE_W:0] N_EXT = (NODE_W + 1)'(N_NODES);
    localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_PATH);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_DEQ, S_SCAN, S_TRACE, S_PACK, S_FAIL, S_OVF} state_t;

    state_t                    state_q, state_d;
    logic                      start_q, start_d;
    logic [NODE_W-1:0]         s_q, s_d, e_q, e_d;
    logic [N_NODES-1:0]        adj_q [N_NODES];
    logic [N_NODES-1:0]        adj_d [N_NODES];
    logic [N_NODES-1:0]        visited_q, visited_d;
    logic [IDX_W-1:0]          parent_q [N_NODES];
    logic [IDX_W-1:0]          parent_d [N_NODES];
    logic [IDX_W-1:0]          queue_q [N_NODES];
    logic [IDX_W-1:0]          queue_d [N_NODES];
    logic [IDX_W-1:0]          head_q, head_d, tail_q, tail_d;
    logic [IDX_W-1:0]          u_q, u_d, v_q, v_d, cur_q, cur_d;
    logic [NODE_W-1:0]         tbuf_q [MAX_PATH];
    logic [NODE_W-1:0]         tbuf_d [MAX_PATH];
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      done_q, done_d, busy_q, busy_d;
    logic                      no_path_q, no_path_d, path_ovf_q, path_ovf_d;
    logic [LEN_W-1:0]          path_len_q, path_len_d;
    logic [MAX_PATH*NODE_W-1:0] final_path_q, final_path_d;

    logic                      start_edge, s_bad, e_bad, wr_ok;
    logic [IDX_W-1:0]          s_idx, e_idx;
    logic [MAX_PATH*NODE_W-1:0] pad_all;

    assign start_edge = start & ~start_q;
    assign s_bad = {1'b0, s_q} >= N_EXT;
    assign e_bad = {1'b0, e_q} >= N_EXT;
    assign s_idx = s_q[IDX_W-1:0];
    assign e_idx = e_q[IDX_W-1:0];
    assign pad_all = {MAX_PATH{PAD}};
    assign wr_ok = edge_we && (state_q == S_IDLE) && ({1'b0, edge_a} < N_EXT) && ({1'b0, edge_b} < N_EXT);

    // Queue pointer advance; the queue can never look falsely empty because
    // each node is enqueued at most once and the start node is popped first.
    function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            adj_q        <= '{default: '0};
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            no_path_q    <= 1'b0;
            path_ovf_q   <= 1'b0;
            path_len_q   <= '0;
            final_path_q <= '0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            s_q          <= s_d;
            e_q          <= e_d;
            adj_q        <= adj_d;
            visited_q    <= visited_d;
            parent_q     <= parent_d;
            queue_q      <= queue_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            u_q          <= u_d;
            v_q          <= v_d;
            cur_q        <= cur_d;
            tbuf_q       <= tbuf_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            no_path_q    <= no_path_d;
            path_ovf_q   <= path_ovf_d;
            path_len_q   <= path_len_d;
            final_path_q <= final_path_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start_edge ? S_INIT : S_IDLE;
            S_INIT:  state_d = (s_bad || e_bad) ? S_FAIL : S_DEQ;
            S_DEQ:   state_d = (head_q == tail_q) ? S_FAIL : (queue_q[head_q] == e_idx) ? S_TRACE : S_SCAN;
            S_SCAN:  state_d = (v_q == LAST) ? S_DEQ : S_SCAN;
            // Overflow wins even on the node that would have closed the path.
            S_TRACE: state_d = (cnt_q + 1'b1 > MAXP) ? S_OVF : (cur_q == s_idx) ? S_PACK : S_TRACE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_d      = start;
        s_d          = s_q;
        e_d          = e_q;
        adj_d        = adj_q;
        visited_d    = visited_q;
        parent_d     = parent_q;
        queue_d      = queue_q;
        head_d       = head_q;
        tail_d       = tail_q;
        u_d          = u_q;
        v_d          = v_q;
        cur_d        = cur_q;
        tbuf_d       = tbuf_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        busy_d       = busy_q;
        no_path_d    = no_path_q;
        path_ovf_d   = path_ovf_q;
        path_len_d   = path_len_q;
        final_path_d = final_path_q;
        if (wr_ok) begin
            adj_d[edge_a[IDX_W-1:0]][edge_b[IDX_W-1:0]] = edge_val;
            adj_d[edge_b[IDX_W-1:0]][edge_a[IDX_W-1:0]] = edge_val;
        end
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    s_d    = s_node;
                    e_d    = e_node;
                    done_d = 1'b0;
                    busy_d = 1'b1;
                end
            end
            S_INIT: begin
                visited_d  = '0;
                parent_d   = '{default: '0};
                queue_d    = '{default: '0};
                head_d     = '0;
                tail_d     = '0;
                no_path_d  = 1'b0;
                path_ovf_d = 1'b0;
                if (!(s_bad || e_bad)) begin
                    queue_d[0]        = s_idx;
                    tail_d            = inc('0);
                    visited_d[s_idx]  = 1'b1;
                    parent_d[s_idx]   = s_idx;
                end
            end
            S_DEQ: begin
                if (head_q != tail_q) begin
                    u_d    = queue_q[head_q];
                    head_d = inc(head_q);
                    v_d    = '0;
                    cur_d  = e_idx;
                    cnt_d  = '0;
                end
            end
            S_SCAN: begin
                if (adj_q[u_q][v_q] && !visited_q[v_q]) begin
                    visited_d[v_q]  = 1'b1;
                    parent_d[v_q]   = u_q;
                    queue_d[tail_q] = v_q;
                    tail_d          = inc(tail_q);
                end
                v_d = v_q + 1'b1;
            end
            S_TRACE: begin
                if (cnt_q < MAXP) tbuf_d[cnt_q[TB_W-1:0]] = NODE_W'(cur_q);
                cnt_d = cnt_q + 1'b1;
                cur_d = parent_q[cur_q];
            end
            S_PACK: begin
                // Buffer holds e..s; slot k takes entry cnt-1-k so slot 0 is s.
                for (int k = 0; k < MAX_PATH; k++)
                    final_path_d[k*NODE_W +: NODE_W] = (CNT_W'(k) < cnt_q) ? tbuf_q[TB_W'(cnt_q - CNT_W'(k) - CNT_W'(1))] : PAD;
                path_len_d = cnt_q[LEN_W-1:0];
                done_d     = 1'b1;
                busy_d     = 1'b0;
            end
            S_FAIL: begin
                no_path_d    = 1'b1;
                path_len_d   = '0;
                final_path_d = pad_all;
                done_d       = 1'b1;
                busy_d       = 1'b0;
            end
            S_OVF: begin
                path_ovf_d   = 1'b1;
                path_len_d   = '0;
                final_path_d = pad_all;
                done_d       = 1'b1;
                busy_d       = 1'b0;
            end
            default: ;
        endcase
    end

    assign done       = done_q;
    assign busy       = busy_q;
    assign no_path    = no_path_q;
    assign path_ovf   = path_ovf_q;
    assign path_len   = path_len_q;
    assign final_path = final_path_q;
endmodule

// File: tb/tb_path_planner_bfs.sv
// tb_path_planner_bfs: directed and random plans checked against a queue-based BFS model
module tb_path_planner_bfs;
    localparam int NN = 32;
    localparam int NW = 6;
    localparam int MP = 10;
    localparam logic [NW-1:0] PADV = 6'd27;

    logic           clk, rst_n, start, edge_we, edge_val;
    logic [NW-1:0]  s_node, e_node, edge_a, edge_b;
    logic           done, busy, no_path, path_ovf;
    logic [3:0]     path_len;
    logic [MP*NW-1:0] final_path;

    int n_assert = 0;
    int n_fail = 0;
    bit madj [NN][NN];

    path_planner_bfs #(.N_NODES(NN), .NODE_W(NW), .MAX_PATH(MP), .PAD(PADV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_node(s_node), .e_node(e_node),
        .edge_we(edge_we), .edge_a(edge_a), .edge_b(edge_b), .edge_val(edge_val),
        .done(done), .busy(busy), .no_path(no_path), .path_ovf(path_ovf),
        .path_len(path_len), .final_path(final_path)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MP*NW-1:0] pads();
        logic [MP*NW-1:0] f;
        for (int k = 0; k < MP; k++) f[k*NW +: NW] = PADV;
        return f;
    endfunction

    task automatic mwr(input int a, input int b, input bit v);
        if (a < NN && b < NN) begin
            madj[a][b] = v;
            madj[b][a] = v;
        end
    endtask

    task automatic wr(input int a, input int b, input bit v);
        edge_a = NW'(a);
        edge_b = NW'(b);
        edge_val = v;
        edge_we = 1;
        step;
        edge_we = 0;
        mwr(a, b, v);
    endtask

    // Plain BFS with ascending neighbour order; latency derived from the
    // per-state cycle costs: 2 to first pop, N+1 per non-target pop.
    function automatic void model(input int s, input int e, output logic np, output logic ovf,
                                  output int len, output logic [MP*NW-1:0] fp, output int lat);
        int q[$];
        int path[$];
        int par[NN];
        bit vis[NN];
        int d, u, n;
        bit found;
        np = 0; ovf = 0; len = 0; fp = pads(); lat = 0;
        if (s >= NN || e >= NN) begin
            np = 1; lat = 2;
            return;
        end
        for (int i = 0; i < NN; i++) vis[i] = 0;
        vis[s] = 1; par[s] = s; q.push_back(s); d = 0; found = 0;
        while (q.size() > 0) begin
            u = q.pop_front();
            if (u == e) begin
                found = 1;
                break;
            end
            d++;
            for (int v = 0; v < NN; v++)
                if (madj[u][v] && !vis[v]) begin
                    vis[v] = 1; par[v] = u; q.push_back(v);
                end
        end
        if (!found) begin
            np = 1; lat = 3 + d * (NN + 1);
            return;
        end
        n = e;
        path.push_front(n);
        while (n != s) begin
            n = par[n];
            path.push_front(n);
        end
        if (path.size() > MP) begin
            ovf = 1; lat = 3 + d * (NN + 1) + MP + 1;
            return;
        end
        len = path.size();
        for (int k = 0; k < len; k++) fp[k*NW +: NW] = NW'(path[k]);
        lat = 4 + d * (NN + 1) + len - 1;
    endfunction

    task automatic run_plan(input string tag, input int s, input int e, input bit cw,
                            input int ca, input int cb, input bit cv, input bit bw);
        logic np, ovf;
        int len, lat, got;
        logic [MP*NW-1:0] fp;
        if (cw) mwr(ca, cb, cv);
        model(s, e, np, ovf, len, fp, lat);
        s_node = NW'(s);
        e_node = NW'(e);
        start = 1;
        if (cw) begin
            edge_we = 1; edge_a = NW'(ca); edge_b = NW'(cb); edge_val = cv;
        end
        step;
        start = 0;
        edge_we = bw;
        if (bw) begin
            edge_a = 0; edge_b = 8; edge_val = 1;
        end
        chk({tag, "/busy_edge0"}, {62'd0, done, busy}, 64'd1);
        got = -1;
        for (int k = 1; k <= 3000; k++) begin
            step;
            if (k == 3) edge_we = 0;
            if (done) begin
                got = k;
                break;
            end
        end
        edge_we = 0;
        chk({tag, "/latency"}, 64'(got), 64'(lat));
        chk({tag, "/busy"}, 64'(busy), 64'd0);
        chk({tag, "/no_path"}, 64'(no_path), 64'(np));
        chk({tag, "/path_ovf"}, 64'(path_ovf), 64'(ovf));
        chk({tag, "/path_len"}, 64'(path_len), 64'(len));
        chk({tag, "/final_path"}, 64'(final_path), 64'(fp));
    endtask

    initial begin
        logic np, ovf;
        int len, lat, falls, rise_at;
        logic prev;
        logic [MP*NW-1:0] fp;
        rst_n = 0; start = 0; edge_we = 0; edge_val = 0;
        s_node = 0; e_node = 0; edge_a = 0; edge_b = 0;
        repeat (2) step;
        chk("rst/done", 64'(done), 64'd1);
        chk("rst/busy", 64'(busy), 64'd0);
        chk("rst/flags", {62'd0, no_path, path_ovf}, 64'd0);
        chk("rst/path_len", 64'(path_len), 64'd0);
        chk("rst/final_path", 64'(final_path), 64'd0);
        rst_n = 1;
        step;

        for (int i = 0; i < 8; i++) wr(i, i + 1, 1);
        wr(3, 40, 1);
        run_plan("chain8", 0, 8, 0, 0, 0, 0, 1);

        for (int i = 0; i < 8; i++) wr(i, i + 1, 0);
        wr(0, 1, 1); wr(0, 2, 1); wr(1, 3, 1); wr(2, 3, 1); wr(5, 5, 1);
        run_plan("diamond", 0, 3, 0, 0, 0, 0, 0);
        run_plan("diamond_rm", 0, 3, 1, 1, 3, 0, 0);
        run_plan("isolated", 0, 10, 0, 0, 0, 0, 0);
        run_plan("oor_e", 0, 40, 0, 0, 0, 0, 0);
        run_plan("oor_s", 33, 2, 0, 0, 0, 0, 0);
        run_plan("self_loop", 5, 0, 0, 0, 0, 0, 0);

        wr(0, 2, 0);
        for (int i = 0; i < 11; i++) wr(i, i + 1, 1);
        run_plan("ovf", 0, 11, 0, 0, 0, 0, 0);
        run_plan("len10", 0, 9, 0, 0, 0, 0, 0);

        model(11, 11, np, ovf, len, fp, lat);
        s_node = 11; e_node = 11; start = 1;
        prev = 1; falls = 0; rise_at = -1;
        for (int k = 0; k <= 100; k++) begin
            step;
            if (prev && !done) falls++;
            if (!prev && done && rise_at < 0) rise_at = k;
            prev = done;
        end
        start = 0;
        step;
        chk("hold/plans", 64'(falls), 64'd1);
        chk("hold/latency", 64'(rise_at), 64'(lat));
        chk("hold/path_len", 64'(path_len), 64'(len));
        chk("hold/final_path", 64'(final_path), 64'(fp));

        s_node = 0; e_node = 8; start = 1;
        step;
        start = 0;
        repeat (6) step;
        chk("midscan/busy", 64'(busy), 64'd1);
        rst_n = 0;
        step;
        rst_n = 1;
        chk("midrst/done", 64'(done), 64'd1);
        chk("midrst/busy", 64'(busy), 64'd0);
        chk("midrst/flags", {62'd0, no_path, path_ovf}, 64'd0);
        chk("midrst/path_len", 64'(path_len), 64'd0);
        chk("midrst/final_path", 64'(final_path), 64'd0);
        for (int i = 0; i < NN; i++)
            for (int j = 0; j < NN; j++) madj[i][j] = 0;
        step;
        run_plan("after_rst", 0, 8, 0, 0, 0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            repeat (45) wr($urandom_range(0, 39), $urandom_range(0, 39), $urandom_range(0, 4) != 0);
            run_plan($sformatf("rnd%0d_a", r), $urandom_range(0, 33), $urandom_range(0, 31), 0, 0, 0, 0, 0);
            run_plan($sformatf("rnd%0d_b", r), $urandom_range(0, 31), $urandom_range(0, 33), 0, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
